// File: rtl/en_gen_pkg.sv
// en_gen_pkg: shared defaults, width helper and period type for the enable-generator blocks
package en_gen_pkg;
   localparam int CLK_HZ_DEF  = 100_000_000;
   localparam int TICK_HZ_DEF = 1000;
   localparam int PW_DEF      = 16;
   typedef logic [PW_DEF-1:0] period_t;
   // width of a counter/index over 0..v-1, never less than one bit
   function automatic int clog2(input int v);
      return (v < 2) ? 1 : $clog2(v);
   endfunction
endpackage

// File: rtl/en_gen_chan.sv
// en_gen_chan: one programmable enable channel with shadowed, wrap-aligned period updates
module en_gen_chan import en_gen_pkg::*; #(
   parameter int PW          = PW_DEF,
   parameter int INIT_PERIOD = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          tick,
   input  logic          wr,
   input  logic [PW-1:0] wr_period,
   output logic          en,
   output logic          sq
);
   logic [PW-1:0] cnt_q, cnt_d, period_q, period_d, shadow_q, shadow_d;
   logic          pend_q, pend_d, off, apply;
   // a disabled channel applies its shadow at once; a running one only at its wrap
   always_comb begin
      off      = (period_q == '0);
      en       = tick & ~off & (cnt_q == period_q - PW'(1));
      sq       = cnt_q < (period_q >> 1);
      apply    = pend_q & (en | off);
      period_d = apply ? shadow_q : period_q;
      cnt_d    = (apply | off | en) ? '0 : cnt_q + PW'(tick);
      shadow_d = wr ? wr_period : shadow_q;
      pend_d   = wr | (pend_q & ~apply);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         period_q <= PW'(INIT_PERIOD);
         shadow_q <= PW'(INIT_PERIOD);
         pend_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         period_q <= period_d;
         shadow_q <= shadow_d;
         pend_q   <= pend_d;
      end
   end
endmodule

// File: rtl/en_gen_multi.sv
// en_gen_multi: prescaled tick, 1 s strobe, 0.5 s square wave and NCH programmable channels
module en_gen_multi import en_gen_pkg::*; #(
   parameter int CLK_HZ      = CLK_HZ_DEF,
   parameter int TICK_HZ     = TICK_HZ_DEF,
   parameter int NCH         = 4,
   parameter int PW          = PW_DEF,
   parameter int INIT_PERIOD = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   run,
   input  logic                   cfg_wr,
   input  logic [clog2(NCH)-1:0]  cfg_ch,
   input  logic [PW-1:0]          cfg_period,
   output logic                   tick_en,
   output logic                   sec_en,
   output logic                   half_sec,
   output logic [NCH-1:0]         ch_en,
   output logic [NCH-1:0]         ch_sq
);
   localparam int DIV   = CLK_HZ / TICK_HZ;
   localparam int PRE_W = clog2(DIV);
   localparam int SEC_W = clog2(TICK_HZ);
   localparam int CW    = clog2(NCH);
   if (CLK_HZ % TICK_HZ != 0) begin : g_bad_div
      $error("en_gen_multi: CLK_HZ must be a multiple of TICK_HZ");
   end
   if (TICK_HZ % 2 != 0) begin : g_bad_tick
      $error("en_gen_multi: TICK_HZ must be even");
   end
   if (NCH < 1 || NCH > 16) begin : g_bad_nch
      $error("en_gen_multi: NCH must be within 1..16");
   end
   logic [PRE_W-1:0] pre_q, pre_d;
   logic [SEC_W-1:0] sec_q, sec_d;
   always_comb begin
      tick_en  = run & (pre_q == PRE_W'(DIV - 1));
      sec_en   = tick_en & (sec_q == SEC_W'(TICK_HZ - 1));
      half_sec = sec_q < SEC_W'(TICK_HZ / 2);
      pre_d    = ~run ? pre_q : tick_en ? '0 : pre_q + PRE_W'(1);
      sec_d    = sec_en ? '0 : sec_q + SEC_W'(tick_en);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         pre_q <= '0;
         sec_q <= '0;
      end else begin
         pre_q <= pre_d;
         sec_q <= sec_d;
      end
   end
   for (genvar i = 0; i < NCH; i++) begin : g_ch
      en_gen_chan #(.PW(PW), .INIT_PERIOD(INIT_PERIOD)) u_ch (
         .clk       (clk),
         .rst       (rst),
         .tick      (tick_en),
         .wr        (cfg_wr & (cfg_ch == CW'(i))),
         .wr_period (cfg_period),
         .en        (ch_en[i]),
         .sq        (ch_sq[i])
      );
   end
endmodule

// File: tb/tb_en_gen_multi.sv
// tb_en_gen_multi: randomized and directed checks of en_gen_multi against a tick-count reference model
module tb_en_gen_multi;
   localparam int CLK_HZ = 1000;
   localparam int TICK   = 10;
   localparam int DIV    = CLK_HZ / TICK;
   localparam int NCH    = 3;
   localparam int PW     = 8;
   localparam int VW     = 3 + 2 * NCH;
   localparam logic [VW-1:0] RST_OUT = {3'b001, {2*NCH{1'b0}}};
   logic clk = 1'b0, rst = 1'b1, run = 1'b0, cfg_wr = 1'b0;
   logic [1:0]    cfg_ch = '0;
   logic [PW-1:0] cfg_period = '0;
   logic tick_en, sec_en, half_sec;
   logic [NCH-1:0] ch_en, ch_sq;
   int checks = 0, errors = 0;
   en_gen_multi #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK), .NCH(NCH), .PW(PW), .INIT_PERIOD(0)) dut (
      .clk(clk), .rst(rst), .run(run), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_period(cfg_period),
      .tick_en(tick_en), .sec_en(sec_en), .half_sec(half_sec), .ch_en(ch_en), .ch_sq(ch_sq)
   );
   always #5 clk = ~clk;
   // reference: run cycles and ticks since reset; each channel tracks ticks since its last apply
   int act = 0, nt = 0;
   int m_per[NCH], m_sh[NCH], m_since[NCH];
   bit m_pend[NCH];
   function automatic void model_reset();
      act = 0;
      nt  = 0;
      for (int k = 0; k < NCH; k++) begin
         m_per[k] = 0; m_sh[k] = 0; m_since[k] = 0; m_pend[k] = 0;
      end
   endfunction
   function automatic logic [VW-1:0] model_out();
      logic t;
      logic [NCH-1:0] en, sq;
      int c;
      t = run && (act % DIV == DIV - 1);
      for (int k = 0; k < NCH; k++) begin
         if (m_per[k] == 0) begin
            en[k] = 0; sq[k] = 0;
         end else begin
            c = m_since[k] % m_per[k];
            en[k] = t && (c == m_per[k] - 1);
            sq[k] = c < m_per[k] / 2;
         end
      end
      return {t, t && (nt % TICK == TICK - 1), (nt % TICK) < TICK / 2, en, sq};
   endfunction
   function automatic void model_step();
      logic [VW-1:0] o;
      o = model_out();
      if (rst) begin
         model_reset();
         return;
      end
      if (run) act++;
      if (o[VW-1]) nt++;
      for (int k = 0; k < NCH; k++) begin
         if (m_pend[k] && (o[NCH+k] || m_per[k] == 0)) begin
            m_per[k] = m_sh[k]; m_since[k] = 0; m_pend[k] = 0;
         end else if (m_per[k] != 0 && o[VW-1]) m_since[k]++;
         if (cfg_wr && int'(cfg_ch) == k) begin
            m_sh[k] = int'(cfg_period); m_pend[k] = 1;
         end
      end
   endfunction
   task automatic cyc(output logic [VW-1:0] a, output logic [VW-1:0] e);
      @(negedge clk);
      e = model_out();
      a = {tick_en, sec_en, half_sec, ch_en, ch_sq};
      @(posedge clk);
      model_step();
      #1;
   endtask
   task automatic do_reset();
      logic [VW-1:0] a, e;
      rst = 1; run = 0; cfg_wr = 0;
      cyc(a, e);
      cyc(a, e);
      rst = 0;
   endtask
   task automatic test_reset();
      logic [VW-1:0] a, e;
      do_reset();
      cyc(a, e);
      checks++;
      if (a !== RST_OUT) begin errors++; $display("FAIL reset_values got %b exp %b", a, RST_OUT); end
      run = 1;
      for (int i = 0; i < 5; i++) begin
         cyc(a, e);
         checks++;
         if (a !== e) begin errors++; $display("FAIL reset_run cyc %0d got %b exp %b", i, a, e); end
      end
   endtask
   task automatic test_tick();
      logic [VW-1:0] a, e;
      int n_t = 0, n_s = 0, s1 = -1, s2 = -1, n_h = 0, ft = -1;
      do_reset();
      run = 1;
      for (int i = 0; i < 2000; i++) begin
         cyc(a, e);
         checks++;
         if (a !== e) begin errors++; $display("FAIL tick cyc %0d got %b exp %b", i, a, e); end
         if (a[VW-1] === 1'b1) begin n_t++; if (ft < 0) ft = i; end
         if (a[VW-2] === 1'b1) begin if (n_s == 0) s1 = i; else s2 = i; n_s++; end
         if (i < 1000 && a[VW-3] === 1'b1) n_h++;
      end
      checks++;
      if (n_t != 20 || ft != 99 || n_s != 2 || s1 != 999 || s2 != 1999 || n_h != 500) begin
         errors++;
         $display("FAIL tick_timing got ticks=%0d first=%0d secs=%0d at %0d,%0d half=%0d exp 20 99 2 999,1999 500",
                  n_t, ft, n_s, s1, s2, n_h);
      end
   endtask
   task automatic test_wrap_write();
      logic [VW-1:0] a, e, p;
      int w = -1, p1 = -1, p2 = -1;
      bit hw = 0;
      do_reset();
      run = 1; cfg_wr = 1; cfg_ch = 2; cfg_period = 3;
      cyc(a, e);
      cfg_period = 2;
      cyc(a, e);
      cfg_wr = 0;
      for (int i = 0; i < 1200; i++) begin
         p = model_out();
         if (w < 0 && p[NCH+2]) begin cfg_wr = 1; cfg_ch = 2; cfg_period = 5; w = i; end
         cyc(a, e);
         cfg_wr = 0;
         checks++;
         if (a !== e) begin errors++; $display("FAIL wrap_write cyc %0d got %b exp %b", i, a, e); end
         if (a[NCH+2] === 1'b1) begin
            if (i == w) hw = 1;
            else if (w >= 0 && p1 < 0) p1 = i;
            else if (w >= 0 && p2 < 0) p2 = i;
         end
      end
      checks++;
      if (!hw || w < 0 || p1 != w + 200 || p2 != w + 700) begin
         errors++;
         $display("FAIL wrap_write_intervals got wrap=%0d hit=%0d next=%0d,%0d exp next=+200,+700", w, hw, p1, p2);
      end
   endtask
   task automatic test_run_pause();
      logic [VW-1:0] a, e;
      int t[$];
      do_reset();
      for (int i = 0; i < 400; i++) begin
         run = !(i >= 250 && i < 287);
         cyc(a, e);
         checks++;
         if (a !== e) begin errors++; $display("FAIL run_pause cyc %0d got %b exp %b", i, a, e); end
         if (a[VW-1] === 1'b1) t.push_back(i);
      end
      checks++;
      if (t.size() != 3 || t[0] != 99 || t[1] != 199 || t[2] != 336) begin
         errors++;
         $display("FAIL run_pause_ticks got n=%0d last=%0d exp n=3 last=336", t.size(), t.size() ? t[t.size()-1] : -1);
      end
      run = 1;
   endtask
   task automatic test_back_to_back();
      logic [VW-1:0] a, e;
      int t[$];
      do_reset();
      run = 1;
      for (int i = 0; i < 800; i++) begin
         cfg_wr = (i == 0 || i == 5 || i == 6);
         cfg_ch = 0;
         cfg_period = (i == 0) ? 8'd3 : (i == 5) ? 8'd6 : 8'd2;
         cyc(a, e);
         checks++;
         if (a !== e) begin errors++; $display("FAIL back_to_back cyc %0d got %b exp %b", i, a, e); end
         if (a[NCH] === 1'b1) t.push_back(i);
      end
      cfg_wr = 0;
      checks++;
      if (t.size() != 3 || t[0] != 299 || t[1] != 499 || t[2] != 699) begin
         errors++;
         $display("FAIL back_to_back_pulses got n=%0d first=%0d exp n=3 at 299,499,699", t.size(), t.size() ? t[0] : -1);
      end
   endtask
   task automatic test_random();
      logic [VW-1:0] a, e;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         run = ($urandom_range(0, 15) != 0);
         cfg_wr = ($urandom_range(0, 19) == 0);
         cfg_ch = 2'($urandom_range(0, 3));
         cfg_period = PW'($urandom_range(0, 6));
         cyc(a, e);
         checks++;
         if (a !== e) begin errors++; $display("FAIL random cyc %0d got %b exp %b", i, a, e); end
      end
      cfg_wr = 0; run = 1;
   endtask
   task automatic test_reset_mid();
      logic [VW-1:0] a, e;
      int ft = -1;
      bit bad = 0;
      do_reset();
      run = 1;
      for (int i = 0; i <= 450; i++) begin
         cfg_wr = (i == 20 || i == 450);
         cfg_ch = (i == 20) ? 2'd3 : 2'd0;
         cfg_period = (i == 20) ? 8'd4 : 8'd3;
         rst = (i == 450);
         cyc(a, e);
         checks++;
         if (a !== e) begin errors++; $display("FAIL reset_mid cyc %0d got %b exp %b", i, a, e); end
         if (a[2*NCH-1:0] !== '0) bad = 1;
      end
      rst = 0; cfg_wr = 0;
      for (int j = 0; j < 350; j++) begin
         cyc(a, e);
         checks++;
         if (a !== e) begin errors++; $display("FAIL reset_mid_post cyc %0d got %b exp %b", j, a, e); end
         if (j == 0) begin
            checks++;
            if (a !== RST_OUT) begin errors++; $display("FAIL reset_mid_values got %b exp %b", a, RST_OUT); end
         end
         if (a[VW-1] === 1'b1 && ft < 0) ft = j;
         if (a[2*NCH-1:0] !== '0) bad = 1;
      end
      checks++;
      if (ft != 99 || bad) begin
         errors++;
         $display("FAIL reset_mid_tick got first=%0d chan_active=%0d exp first=99 chan_active=0", ft, bad);
      end
   endtask
   initial begin
      test_reset();
      test_tick();
      test_wrap_write();
      test_run_pause();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
